// File: rtl/trigger_gate.sv
// Trigger gate: synchronizes trig_in, enforces per-trigger deadtime and stop back-pressure, and numbers
// accepted/rejected triggers per live period. Define TRIG_TIMESTAMP_EN to timestamp accepted triggers.
module trigger_gate #(
  parameter int SYNC_STAGES = 2,
  parameter int DEADTIME    = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             live,
  input  logic             trig_in,
  input  logic             stop,
  output logic             live_rising,
  output logic             trig_accepted,
  output logic [CNT_W-1:0] event_id,
  output logic [CNT_W-1:0] n_rejected,
  output logic             busy,
  output logic [31:0]      trig_ts
);

  localparam int DEAD_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, DEAD} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   trig_s;
  logic                   trig_s_d_q;
  logic                   edge_q;
  logic                   live_d_q;
  logic                   live_rising_q;

  state_e                 state_q, state_d;
  logic [DEAD_W-1:0]      dead_cnt_q, dead_cnt_d;
  logic                   acc_q, acc_d;
  logic                   first_q, first_d;
  logic [CNT_W-1:0]       event_id_q, event_id_d;
  logic [CNT_W-1:0]       n_rej_q, n_rej_d;
  logic                   rej;
  logic                   period_start;

  assign trig_s = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q        <= '0;
      trig_s_d_q    <= 1'b0;
      edge_q        <= 1'b0;
      live_d_q      <= 1'b0;
      live_rising_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], trig_in};
      trig_s_d_q    <= trig_s;
      edge_q        <= trig_s & ~trig_s_d_q;
      live_d_q      <= live;
      live_rising_q <= live & ~live_d_q;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    dead_cnt_d   = dead_cnt_q;
    acc_d        = 1'b0;
    first_d      = first_q;
    event_id_d   = event_id_q;
    n_rej_d      = n_rej_q;
    rej          = 1'b0;
    period_start = 1'b0;
    if (!live) begin
      state_d    = IDLE;
      dead_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (live_rising_q) begin
            state_d      = ARMED;
            period_start = 1'b1;
          end
        end
        ARMED: begin
          if (edge_q) begin
            if (stop) begin
              rej = 1'b1;
            end else begin
              acc_d      = 1'b1;
              dead_cnt_d = DEAD_W'(DEADTIME - 1);
              state_d    = DEAD;
              event_id_d = first_q ? '0 : event_id_q + 1'b1;
              first_d    = 1'b0;
            end
          end
        end
        DEAD: begin
          rej = edge_q;
          if (dead_cnt_q == '0) state_d = ARMED;
          else                  dead_cnt_d = dead_cnt_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
      // Counters restart each live period; rejects saturate instead of wrapping.
      if (period_start) begin
        event_id_d = '0;
        n_rej_d    = '0;
        first_d    = 1'b1;
      end else if (rej && (n_rej_q != '1)) begin
        n_rej_d = n_rej_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dead_cnt_q <= '0;
      acc_q      <= 1'b0;
      first_q    <= 1'b0;
      event_id_q <= '0;
      n_rej_q    <= '0;
    end else begin
      state_q    <= state_d;
      dead_cnt_q <= dead_cnt_d;
      acc_q      <= acc_d;
      first_q    <= first_d;
      event_id_q <= event_id_d;
      n_rej_q    <= n_rej_d;
    end
  end

`ifdef TRIG_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, ts_cnt_d;
  logic [31:0] trig_ts_q;

  // ts_cnt reads 0 in the live_rising cycle; trig_ts shows ts_cnt of the trig_accepted cycle.
  assign ts_cnt_d = (live & ~live_d_q) ? 32'd0 :
                    (live ? ts_cnt_q + 32'd1 : ts_cnt_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_cnt_q  <= '0;
      trig_ts_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
      if (period_start) trig_ts_q <= '0;
      else if (acc_d)   trig_ts_q <= ts_cnt_d;
    end
  end

  assign trig_ts = trig_ts_q;
`else
  assign trig_ts = 32'd0;
`endif

  assign live_rising   = live_rising_q;
  assign trig_accepted = acc_q;
  assign event_id      = event_id_q;
  assign n_rejected    = n_rej_q;
  assign busy          = (state_q == DEAD);

endmodule

// File: tb/tb_trigger_gate.sv
// Self-checking bench for trigger_gate: directed scenarios plus randomized traffic, every cycle compared
// against an event-level reference model (trigger times, deadtime window, per-period counts).
module tb_trigger_gate;

  localparam int SYNC_STAGES = 2;
  localparam int DEADTIME    = 16;
  localparam int CNT_W       = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
`ifdef TRIG_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             live = 1'b0;
  logic             trig_in = 1'b0;
  logic             stop = 1'b0;
  logic             live_rising;
  logic             trig_accepted;
  logic [CNT_W-1:0] event_id;
  logic [CNT_W-1:0] n_rejected;
  logic             busy;
  logic [31:0]      trig_ts;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trigger_gate #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEADTIME   (DEADTIME),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .live         (live),
    .trig_in      (trig_in),
    .stop         (stop),
    .live_rising  (live_rising),
    .trig_accepted(trig_accepted),
    .event_id     (event_id),
    .n_rejected   (n_rejected),
    .busy         (busy),
    .trig_ts      (trig_ts)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: triggers are instants (trig_in rise + pipeline), accepts need the period to be
  // armed, stop low and at least DEADTIME+1 cycles since the previous accept.
  int unsigned cyc = 0;
  bit          h1, h2, h3, h4;
  bit          live_prev, active, acc_valid;
  int unsigned last_acc, rise_cyc, n_acc, n_rej;
  bit          m_lr, m_acc, m_busy;
  logic [31:0] m_ts;

  always @(posedge clk) begin
    bit trig_evt;
    bit in_dead;
    cyc++;
    if (!rst_n) begin
      {h1, h2, h3, h4} = '0;
      live_prev = 0; active = 0; acc_valid = 0;
      n_acc = 0; n_rej = 0;
      m_lr = 0; m_acc = 0; m_busy = 0; m_ts = '0;
    end else begin
      trig_evt = h3 & ~h4;
      m_acc    = 0;
      if (!live) begin
        active    = 0;
        acc_valid = 0;
      end else if (!active) begin
        if (m_lr) begin
          active = 1; n_acc = 0; n_rej = 0; m_ts = '0;
        end
      end else if (trig_evt) begin
        in_dead = acc_valid && (cyc - last_acc <= DEADTIME);
        if (in_dead || stop) begin
          n_rej++;
        end else begin
          m_acc = 1; n_acc++; acc_valid = 1; last_acc = cyc;
          m_ts  = TS_EN ? 32'(cyc - rise_cyc) : 32'd0;
        end
      end
      if (live && !live_prev) rise_cyc = cyc;
      m_lr      = live && !live_prev;
      m_busy    = active && acc_valid && (cyc - last_acc < DEADTIME);
      h4 = h3; h3 = h2; h2 = h1; h1 = trig_in;
      live_prev = live;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("live_rising",   live_rising,   m_lr);
      check("trig_accepted", trig_accepted, m_acc);
      check("busy",          busy,          m_busy);
      check("event_id",      event_id,      (n_acc == 0) ? 0 : ((n_acc - 1) & CNT_MAX));
      check("n_rejected",    n_rejected,    (n_rej > CNT_MAX) ? CNT_MAX : n_rej);
      check("trig_ts",       trig_ts,       m_ts);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rise(input int low_after);
    trig_in = 1'b1;
    tick(2);
    trig_in = 1'b0;
    tick(low_after);
  endtask

  task automatic restart_live();
    live = 1'b0;
    tick(3);
    live = 1'b1;
    tick(4);
  endtask

  task automatic wait_acc(input int limit, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!trig_accepted && n < limit);
  endtask

  initial begin
    int n;
    int live_off;

    // Reset with trig_in toggling
    for (int i = 0; i < 3; i++) begin
      trig_in = ~trig_in;
      tick(1);
    end
    check("rst_busy", busy, 0);
    check("rst_acc", trig_accepted, 0);
    trig_in = 1'b0;
    rst_n   = 1'b1;
    tick(4);

    // First trigger of a live period, held high
    live = 1'b1;
    tick(10);
    trig_in = 1'b1;
    wait_acc(20, n);
    check("acc_latency", n, SYNC_STAGES + 2);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick(1);
    end
    check("busy_len", n, DEADTIME);
    check("first_eid", event_id, 0);
    trig_in = 1'b0;
    tick(30);
    check("held_one_edge", event_id, 0);

    // Deadtime rejection then accept
    restart_live();
    rise(6);
    rise(10);
    rise(25);
    check("dead_eid", event_id, 1);
    check("dead_nrej", n_rejected, 1);

    // Stop back-pressure
    restart_live();
    stop = 1'b1;
    for (int i = 0; i < 5; i++) rise(28);
    check("stop_acc_none", event_id, 0);
    check("stop_nrej", n_rejected, 5);
    stop = 1'b0;
    trig_in = 1'b1;
    wait_acc(20, n);
    check("stop_release_acc", trig_accepted, 1);
    trig_in = 1'b0;
    tick(25);

    // live drop during deadtime
    restart_live();
    rise(25);
    rise(6);
    rise(4);
    check("drop_busy_before", busy, 1);
    check("drop_nrej_before", n_rejected, 1);
    live = 1'b0;
    tick(1);
    check("drop_busy_after", busy, 0);
    tick(3);
    live = 1'b1;
    tick(3);
    check("restart_eid", event_id, 0);
    check("restart_nrej", n_rejected, 0);
    rise(25);
    check("restart_first_eid", event_id, 0);

    // Timestamp 100 cycles after live_rising
    live = 1'b0;
    tick(3);
    live = 1'b1;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!live_rising && n < 10);
    check("lr_seen", live_rising, 1);
    tick(99);
    trig_in = 1'b1;
    wait_acc(20, n);
    check("ts_value", trig_ts, TS_EN ? 100 + SYNC_STAGES + 1 : 0);
    trig_in = 1'b0;
    tick(2);
    rst_n = 1'b0;
    tick(2);
    check("rst_mid_dead_busy", busy, 0);
    check("rst_mid_dead_ts", trig_ts, 0);
    rst_n = 1'b1;
    tick(2);

    // event_id wrap and n_rejected saturation
    restart_live();
    for (int i = 0; i < 20; i++) rise(18);
    check("eid_wrap", event_id, 19 & CNT_MAX);
    stop = 1'b1;
    for (int i = 0; i < 20; i++) rise(2);
    tick(6);
    check("nrej_sat", n_rejected, CNT_MAX);
    stop = 1'b0;

    // Randomized traffic
    live_off = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 5) == 0) trig_in = ~trig_in;
      stop = ($urandom_range(0, 9) < 3);
      if (live_off > 0) begin
        live_off--;
        if (live_off == 0) live = 1'b1;
      end else if ($urandom_range(0, 249) == 0) begin
        live     = 1'b0;
        live_off = $urandom_range(1, 6);
      end
      rst_n = ($urandom_range(0, 999) != 0);
      tick(1);
    end
    rst_n = 1'b1;
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
